// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and writeback source enum
package npc_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - issue, result and register-file write port bundle
interface wb_arbiter_if
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = REG_DATA_W
) ();
    logic                  iss_valid;
    logic                  iss_wen;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic                  iss_ready;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [63:0]           wb_count;

    modport master (
        output iss_valid, iss_wen, iss_rd, rs1, rs2,
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata, wb_count
    );

    modport slave (
        input  iss_valid, iss_wen, iss_rd, rs1, rs2,
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output iss_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata, wb_count
    );
endinterface

// File: rtl/wb_arbiter_scoreboard.sv
// rtl/wb_arbiter_scoreboard.sv - in-flight destination register tracking
module wb_scoreboard
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic                  iss_wen,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  iss_ready,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clear applied before set so a same-cycle reissue keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_idx] = 1'b0;
        if (set_en)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign iss_ready = (iss_rd == '0) | !iss_wen | !busy[iss_rd];
    assign rs1_busy  = busy[rs1];
    assign rs2_busy  = busy[rs2];
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - LSU-first writeback arbiter with ALU anti-starvation
module wb_arbiter
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH   = REG_ADDR_W,
    parameter int DATA_WIDTH   = REG_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    wb_src_e               grant;
    logic [CNT_W-1:0]      starve_cnt;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  wr_fire;
    logic                  iss_set;

    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic [63:0]           wb_count_q;

    always_comb begin
        grant    = WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (rst)
            grant = WB_NONE;
        else if (bus.alu_valid && starve_cnt >= LIMIT)
            grant = WB_ALU;
        else if (bus.lsu_valid)
            grant = WB_LSU;
        else if (bus.alu_valid)
            grant = WB_ALU;
        case (grant)
            WB_ALU: begin
                sel_rd   = bus.alu_rd;
                sel_data = bus.alu_data;
            end
            WB_LSU: begin
                sel_rd   = bus.lsu_rd;
                sel_data = bus.lsu_data;
            end
            default: ;
        endcase
    end

    assign bus.alu_ready = (grant == WB_ALU);
    assign bus.lsu_ready = (grant == WB_LSU);
    assign wr_fire       = (grant != WB_NONE) && (sel_rd != '0);

    always_ff @(posedge clk) begin
        if (rst || !bus.alu_valid || bus.alu_ready)
            starve_cnt <= '0;
        else if (starve_cnt < LIMIT)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // x0 results complete the handshake but leave the write port idle and unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_count_q <= '0;
        end else begin
            rf_wen_q <= wr_fire;
            if (wr_fire) begin
                rf_waddr_q <= sel_rd;
                rf_wdata_q <= sel_data;
                wb_count_q <= wb_count_q + 64'd1;
            end
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.wb_count = wb_count_q;

    assign iss_set = bus.iss_valid && bus.iss_ready && bus.iss_wen && (bus.iss_rd != '0);

    wb_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_set),
        .clr_en    (rf_wen_q),
        .clr_idx   (rf_waddr_q),
        .iss_wen   (bus.iss_wen),
        .iss_rd    (bus.iss_rd),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .iss_ready (bus.iss_ready),
        .rs1_busy  (bus.rs1_busy),
        .rs2_busy  (bus.rs2_busy)
    );
endmodule
